spi_reg_bank: RTL

Register bank that sits directly downstream of top_spi_slave and consumes its decoded transactions (spi_write/spi_read strobes, spi_addr, spi_data). It returns read data to the slave's data_word_send input for the next MISO word. It holds a small general-purpose register file, read-only ID/status words and a sticky error flag. A flattened register vector is exported to fabric logic.

---
 rtl/spi_reg_bank.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank.sv
// SPI register bank: ID/STATUS/ERRCLR words, NUM_REGS general RW registers, sticky error flag.
// Optional write-lock of the general registers (key register at 0xFE) when SPI_REG_LOCK_EN is defined.
module spi_reg_bank #(
   parameter int                    ADDR_LEN  = 8,
   parameter int                    WORD_LEN  = 16,
   parameter logic [ADDR_LEN-1:0]   BASE_ADDR = 8'h80,
   parameter int                    NUM_REGS  = 8,
   parameter logic [WORD_LEN-1:0]   ID_VALUE  = 16'h5A01,
   parameter logic [WORD_LEN-1:0]   ERR_WORD  = 16'hDEAD
) (
   input  logic                         i_master_clock,
   input  logic                         i_rst,
   input  logic                         i_wr_stb,
   input  logic                         i_rd_stb,
   input  logic [ADDR_LEN-1:0]          i_addr,
   input  logic [WORD_LEN-1:0]          i_wdata,
   output logic [WORD_LEN-1:0]          o_rdata,
   output logic                         o_rd_valid,
   output logic                         o_err,
   output logic [NUM_REGS*WORD_LEN-1:0] o_regs
);

   localparam int                  IDXW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_LEN-1:0] A_ID    = '0;
   localparam logic [ADDR_LEN-1:0] A_STAT  = ADDR_LEN'(1);
   localparam logic [ADDR_LEN-1:0] A_CLR   = ADDR_LEN'(2);
   localparam logic [ADDR_LEN:0]   NREGS_W = (ADDR_LEN+1)'(NUM_REGS);

   typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RESP} state_t;

   state_t                             r_state;
   logic [ADDR_LEN-1:0]                r_addr;
   logic [WORD_LEN-1:0]                r_wdata;
   logic [NUM_REGS-1:0][WORD_LEN-1:0]  r_regs;
   logic [7:0]                         r_wr_cnt;
   logic [WORD_LEN-1:0]                r_rdata;
   logic                               r_rd_valid;
   logic                               r_err;

   logic [ADDR_LEN:0]    w_off;
   logic [IDXW-1:0]      w_idx;
   logic                 w_is_id, w_is_stat, w_is_clr, w_is_gen, w_is_lk;
   logic                 w_lock;
   logic                 w_gen_wr, w_wr_ok, w_rd_map;
   logic                 w_err_set, w_err_clr;
   logic [WORD_LEN-1:0]  w_status, w_rd_data;

   // Offset is one bit wider so addresses below BASE_ADDR wrap to a large value and fail the range test
   assign w_off     = {1'b0, r_addr} - {1'b0, BASE_ADDR};
   assign w_idx     = w_off[IDXW-1:0];
   assign w_is_gen  = (w_off < NREGS_W);
   assign w_is_id   = (r_addr == A_ID);
   assign w_is_stat = (r_addr == A_STAT);
   assign w_is_clr  = (r_addr == A_CLR);

`ifdef SPI_REG_LOCK_EN
   localparam logic [ADDR_LEN-1:0] A_LOCK     = ADDR_LEN'(8'hFE);
   localparam logic [WORD_LEN-1:0] UNLOCK_KEY = WORD_LEN'(16'hA5C3);
   logic r_lock;

   assign w_is_lk = (r_addr == A_LOCK);
   assign w_lock  = r_lock;

   always_ff @(posedge i_master_clock or posedge i_rst) begin
      if (i_rst)
         r_lock <= 1'b1;
      else if (r_state == S_WR && w_is_lk)
         r_lock <= (r_wdata != UNLOCK_KEY);
   end
`else
   assign w_is_lk = 1'b0;
   assign w_lock  = 1'b0;
`endif

   assign w_gen_wr = w_is_gen && !w_lock;
   assign w_wr_ok  = w_gen_wr || w_is_clr || w_is_lk;
   assign w_rd_map = w_is_id || w_is_stat || w_is_clr || w_is_gen || w_is_lk;
   assign w_status = WORD_LEN'({r_wr_cnt, 6'b0, r_err, w_lock});

   always_comb begin
      w_rd_data = ERR_WORD;
      if (w_is_id)        w_rd_data = ID_VALUE;
      else if (w_is_stat) w_rd_data = w_status;
      else if (w_is_clr)  w_rd_data = '0;
      else if (w_is_gen)  w_rd_data = r_regs[w_idx];
      else if (w_is_lk)   w_rd_data = WORD_LEN'(w_lock);
   end

   // Any error source in the same cycle as an ERRCLR write takes priority over the clear
   assign w_err_set = ((r_state == S_IDLE) && i_wr_stb && i_rd_stb)
                   || ((r_state != S_IDLE) && (i_wr_stb || i_rd_stb))
                   || ((r_state == S_WR) && !w_wr_ok)
                   || ((r_state == S_RD) && !w_rd_map);
   assign w_err_clr = (r_state == S_WR) && w_is_clr;

   always_ff @(posedge i_master_clock or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_regs     <= '0;
         r_wr_cnt   <= '0;
         r_rdata    <= '0;
         r_rd_valid <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         if (w_err_set)      r_err <= 1'b1;
         else if (w_err_clr) r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_wr_stb) begin
                  r_addr  <= i_addr;
                  r_wdata <= i_wdata;
                  r_state <= S_WR;
               end else if (i_rd_stb) begin
                  r_addr  <= i_addr;
                  r_state <= S_RD;
               end
            end
            S_WR: begin
               if (w_gen_wr) r_regs[w_idx] <= r_wdata;
               if (w_wr_ok)  r_wr_cnt      <= r_wr_cnt + 8'd1;
               r_state <= S_IDLE;
            end
            S_RD: begin
               r_rdata    <= w_rd_data;
               r_rd_valid <= 1'b1;
               r_state    <= S_RESP;
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_rdata    = r_rdata;
   assign o_rd_valid = r_rd_valid;
   assign o_err      = r_err;
   assign o_regs     = r_regs;

endmodule
